if_stage: RTL and testbench

Instruction-fetch stage of the five-stage pipeline. It owns the PC, drives the synchronous instruction ROM, and loads the IF/ID pipeline register that feeds the instruction decoder. It is the supplier end of the decoder interface: it produces `instruction` plus its PC for ID, and it consumes the resolved `npc_op`, base and immediate from EX to redirect fetch. Branches are predicted not-taken, and a squashed slot is filled with the all-zero bubble word, which the decoder handles as a no-write PLUS_4 slot.

---
 rtl/if_stage.sv | 56 +++++
 tb/tb_if_stage.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// if_stage: PC owner, ROM fetch and IF/ID register with not-taken prediction and EX redirect
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          IROM_AW  = 14
) (
  input  logic               clk,
  input  logic               rst,
  output logic [IROM_AW-1:0] irom_addr,
  input  logic [31:0]        irom_data,
  input  logic               stall,
  input  logic               redirect_valid,
  input  logic [2:0]         redirect_op,
  input  logic               branch_taken,
  input  logic [31:0]        redirect_base,
  input  logic [31:0]        redirect_imm,
  output logic [31:0]        id_inst,
  output logic [31:0]        id_pc,
  output logic [31:0]        id_pc4,
  output logic               id_valid,
  output logic               misalign_err
);
  logic [31:0] pc_f, pc_f4, sum, target, next_pc;
  logic        fetch_ok, take;
  always_comb begin
    take = redirect_valid && (redirect_op == 3'd2 || redirect_op == 3'd3 ||
                              (redirect_op == 3'd1 && branch_taken));
    sum = redirect_base + redirect_imm;
    target = redirect_op == 3'd3 ? {sum[31:1], 1'b0} : sum;
    pc_f4 = pc_f + 32'd4;
    next_pc = rst ? RESET_PC : take ? target : stall ? pc_f : pc_f4;
  end
  assign irom_addr = next_pc[IROM_AW+1:2];
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_f <= RESET_PC;
      fetch_ok <= 1'b1;
      id_inst <= '0;
      id_pc <= '0;
      id_pc4 <= '0;
      id_valid <= 1'b0;
      misalign_err <= 1'b0;
    end else if (take) begin
      pc_f <= target;
      fetch_ok <= 1'b1;
      id_inst <= '0;
      id_valid <= 1'b0;
      if (target[1:0] != 2'b00) misalign_err <= 1'b1;
    end else if (!stall) begin
      pc_f <= pc_f4;
      id_inst <= irom_data;
      id_pc <= pc_f;
      id_pc4 <= pc_f4;
      id_valid <= fetch_ok;
    end
  end
endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: directed plan plus randomized fetch/redirect traffic against an architectural model
module tb_if_stage;
  logic        clk = 0, rst, stall, redirect_valid, branch_taken;
  logic [2:0]  redirect_op;
  logic [31:0] redirect_base, redirect_imm, irom_data, id_inst, id_pc, id_pc4;
  logic [13:0] irom_addr;
  logic        id_valid, misalign_err;
  int checks = 0, errors = 0;

  if_stage dut (
    .clk(clk), .rst(rst), .irom_addr(irom_addr), .irom_data(irom_data), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_op(redirect_op), .branch_taken(branch_taken),
    .redirect_base(redirect_base), .redirect_imm(redirect_imm), .id_inst(id_inst),
    .id_pc(id_pc), .id_pc4(id_pc4), .id_valid(id_valid), .misalign_err(misalign_err));

  always #5 clk = ~clk;

  function automatic logic [31:0] rom_word(input logic [31:0] word_addr);
    return 32'h1000_0000 + word_addr;
  endfunction

  always @(posedge clk) irom_data <= rom_word({18'b0, irom_addr});

  // architectural state: the PC whose word is in flight, and the decoder-visible slot
  logic [31:0] m_pc, m_inst, m_id_pc, m_id_pc4, m_addr;
  logic        m_valid, m_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic r, input logic st, input logic rv, input logic [2:0] op,
                       input logic bt, input logic [31:0] base, input logic [31:0] imm);
    rst = r; stall = st; redirect_valid = rv; redirect_op = op; branch_taken = bt;
    redirect_base = base; redirect_imm = imm;
  endtask

  task automatic step();
    logic jump;
    logic [31:0] dest;
    jump = redirect_valid && (redirect_op == 2 || redirect_op == 3 || (redirect_op == 1 && branch_taken));
    dest = redirect_base + redirect_imm;
    if (redirect_op == 3) dest[0] = 1'b0;
    m_addr = rst ? 32'd0 : jump ? dest : stall ? m_pc : m_pc + 4;
    #1 chk("irom_addr", {18'b0, irom_addr}, {18'b0, m_addr[15:2]});
    if (rst) begin
      m_pc = 0; m_inst = 0; m_id_pc = 0; m_id_pc4 = 0; m_valid = 0; m_err = 0;
    end else if (jump) begin
      m_inst = 0; m_valid = 0; m_pc = dest;
      if (dest % 4 != 0) m_err = 1;
    end else if (!stall) begin
      m_inst = rom_word({18'b0, m_pc[15:2]}); m_id_pc = m_pc; m_id_pc4 = m_pc + 4;
      m_valid = 1; m_pc = m_pc + 4;
    end
    @(posedge clk); #1;
    chk("id_inst", id_inst, m_inst);
    chk("id_pc", id_pc, m_id_pc);
    chk("id_pc4", id_pc4, m_id_pc4);
    chk("id_valid", {31'b0, id_valid}, {31'b0, m_valid});
    chk("misalign_err", {31'b0, misalign_err}, {31'b0, m_err});
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin drive(0, 0, 0, 0, 0, 0, 0); step(); end
  endtask

  initial begin
    drive(1, 0, 0, 0, 0, 0, 0);
    #1 chk("rst_addr", {18'b0, irom_addr}, 32'd0);
    step();
    chk("rst_valid", {31'b0, id_valid}, 32'd0);
    chk("rst_inst", id_inst, 32'd0);
    run(1);
    chk("first_inst", id_inst, 32'h1000_0000);
    chk("first_pc", id_pc, 32'd0);
    chk("first_valid", {31'b0, id_valid}, 32'd1);
    run(1);
    chk("second_inst", id_inst, 32'h1000_0001);
    chk("second_pc4", id_pc4, 32'd8);
    run(1);
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 0, 0, 0, 0, 0);
      #1 chk("stall_addr", {18'b0, irom_addr}, 32'd3);
      step();
      chk("stall_pc", id_pc, 32'd8);
      chk("stall_inst", id_inst, 32'h1000_0002);
    end
    run(1);
    chk("after_stall_pc", id_pc, 32'd12);
    drive(0, 0, 1, 2, 0, 32'h20, 32'hFFFF_FFF0); step();
    chk("jump_bubble_valid", {31'b0, id_valid}, 32'd0);
    chk("jump_bubble_inst", id_inst, 32'd0);
    run(1);
    chk("jump_pc", id_pc, 32'h10);
    chk("jump_valid", {31'b0, id_valid}, 32'd1);
    drive(0, 0, 1, 3, 0, 32'h101, 32'h4);
    #1 chk("jalr_addr", {18'b0, irom_addr}, 32'h41);
    step();
    run(1);
    chk("jalr_pc", id_pc, 32'h104);
    chk("jalr_no_err", {31'b0, misalign_err}, 32'd0);
    drive(0, 0, 1, 1, 0, 32'h40, 32'h8); step();
    chk("bnt_pc", id_pc, 32'h108);
    chk("bnt_valid", {31'b0, id_valid}, 32'd1);
    drive(0, 0, 1, 1, 1, 32'h40, 32'h8); step();
    chk("bt_bubble", {31'b0, id_valid}, 32'd0);
    run(1);
    chk("bt_pc", id_pc, 32'h48);
    drive(0, 1, 1, 2, 0, 32'h200, 32'h0); step();
    chk("stall_redirect_bubble", {31'b0, id_valid}, 32'd0);
    run(1);
    chk("stall_redirect_pc", id_pc, 32'h200);
    drive(0, 0, 1, 2, 0, 32'h100, 32'h2); step();
    chk("misalign_set", {31'b0, misalign_err}, 32'd1);
    run(2);
    chk("misalign_sticky", {31'b0, misalign_err}, 32'd1);
    drive(1, 1, 1, 2, 0, 32'h300, 32'h0); step();
    chk("rst_redirect_err", {31'b0, misalign_err}, 32'd0);
    chk("rst_redirect_pc", id_pc, 32'd0);
    run(1);
    chk("restart_inst", id_inst, 32'h1000_0000);
    drive(0, 0, 1, 2, 0, 32'hFFFF_FFF0, 32'hC); step();
    run(2);
    chk("wrap_pc", id_pc, 32'd0);
    chk("wrap_pc4", id_pc4, 32'd4);
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] base, imm;
      base = $urandom_range(0, 3) == 0 ? $urandom : $urandom_range(0, 32'h3FF);
      imm = $urandom_range(0, 1) ? $urandom_range(0, 64) : -$urandom_range(0, 64);
      drive($urandom_range(0, 99) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0,
            3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), base, imm);
      step();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
